// File: rtl/bit_scan_encoder.sv
// Bit scanner: accepts an N-bit word and emits one beat per set bit (lowest first) with popcount/one-hot/none flags.
// First beat is valid the cycle after acceptance; out_ready low freezes every output and the mask.
module bit_scan_encoder #(
   parameter  int N = 8,
   localparam int W = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_idx,
   output logic         out_last,
   output logic         out_none,
   output logic         out_onehot,
   output logic [W:0]   out_cnt
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] EMIT = 1'b1;

   logic [0:0]   state_q, state_d;
   logic [N-1:0] mask_q, mask_d;
   logic [W:0]   cnt_q, cnt_d;
   logic         onehot_q, onehot_d;
   logic         none_q, none_d;

   logic [W:0]   pop;
   logic [W-1:0] low_idx;
   logic [N-1:0] rest;
   logic         single;
   logic         accept;
   logic         fire;

   always_comb begin
      pop = '0;
      for (int i = 0; i < N; i++) begin
         pop = pop + (W+1)'(in_data[i]);
      end
   end

   // Descending scan so the lowest set bit wins; a cleared mask yields index 0.
   always_comb begin
      low_idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (mask_q[i]) begin
            low_idx = W'(i);
         end
      end
   end

   assign rest   = mask_q & (mask_q - N'(1));
   assign single = (rest == '0);
   assign accept = in_valid && (state_q == IDLE);
   assign fire   = out_ready && (state_q == EMIT);

   always_comb begin
      state_d  = state_q;
      mask_d   = mask_q;
      cnt_d    = cnt_q;
      onehot_d = onehot_q;
      none_d   = none_q;
      if (accept) begin
         state_d  = EMIT;
         mask_d   = in_data;
         cnt_d    = pop;
         onehot_d = (pop == (W+1)'(1));
         none_d   = (in_data == '0);
      end else if (fire) begin
         if (single) begin
            state_d = IDLE;
            mask_d  = '0;
         end else begin
            mask_d  = rest;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         mask_q   <= '0;
         cnt_q    <= '0;
         onehot_q <= 1'b0;
         none_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         mask_q   <= mask_d;
         cnt_q    <= cnt_d;
         onehot_q <= onehot_d;
         none_q   <= none_d;
      end
   end

   assign in_ready   = (state_q == IDLE);
   assign out_valid  = (state_q == EMIT);
   assign out_idx    = low_idx;
   assign out_last   = (state_q == EMIT) && single;
   assign out_cnt    = cnt_q;
   assign out_onehot = onehot_q;
   assign out_none   = none_q;

endmodule
